// File: rtl/band_sequencer.sv
// Per-sample controller that runs one shared band filter for the low, mid and high bands, then latches the summer output to the DAC.
// Optional filt_done watchdog: define BAND_SEQ_TIMEOUT_EN.
module band_sequencer #(
    parameter int W         = 23,
    parameter int TO_CYCLES = 255
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic                sample_valid,
    input  logic [11:0]         x_in,
    input  logic [2:0]          band_en,
    input  logic                ovr_clr,
    output logic                filt_start,
    output logic [1:0]          filt_sel,
    output logic [11:0]         filt_x,
    input  logic                filt_done,
    input  logic signed [W-1:0] filt_y,
    output logic signed [W-1:0] ypb,
    output logic signed [W-1:0] ypm,
    output logic signed [W-1:0] ypa,
    input  logic [15:0]         ys_in,
    output logic [11:0]         dac_data,
    output logic                dac_valid,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] START_L = 4'd1;
    localparam logic [3:0] WAIT_L  = 4'd2;
    localparam logic [3:0] START_M = 4'd3;
    localparam logic [3:0] WAIT_M  = 4'd4;
    localparam logic [3:0] START_H = 4'd5;
    localparam logic [3:0] WAIT_H  = 4'd6;
    localparam logic [3:0] SUM     = 4'd7;
    localparam logic [3:0] OUT     = 4'd8;

    logic [3:0]          state_q, state_d;
    logic [2:0]          mask_q, mask_d;
    logic                start_q, start_d;
    logic [1:0]          sel_q, sel_d;
    logic [11:0]         x_q, x_d;
    logic signed [W-1:0] ypb_q, ypb_d;
    logic signed [W-1:0] ypm_q, ypm_d;
    logic signed [W-1:0] ypa_q, ypa_d;
    logic [11:0]         dac_q, dac_d;
    logic                dv_q, dv_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;

    logic                in_wait;
    logic                in_start;
    logic                expire;
    logic                advance;
    logic signed [W-1:0] cap_val;
    logic                unused_ys;

    // Only the low 12 bits of the saturated summer word reach the DAC.
    assign unused_ys = ^ys_in[15:12];

    // First enabled band at or above 'from' (3 means none left), else SUM.
    function automatic logic [3:0] next_start(input logic [1:0] from, input logic [2:0] m);
        if (from == 2'd0 && m[0])
            return START_L;
        else if (from <= 2'd1 && m[1])
            return START_M;
        else if (from <= 2'd2 && m[2])
            return START_H;
        else
            return SUM;
    endfunction

    assign in_wait  = (state_q == WAIT_L) || (state_q == WAIT_M) || (state_q == WAIT_H);
    assign in_start = (state_q == START_L) || (state_q == START_M) || (state_q == START_H);
    assign advance  = in_wait && (filt_done || expire);
    assign cap_val  = filt_done ? filt_y : '0;

`ifdef BAND_SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] wd_q, wd_d;
    logic       terr_q, terr_d;

    // Expiry fires on the TO_CYCLES-th WAIT cycle; a coincident done wins.
    assign expire = in_wait && !filt_done && (wd_q == TO_LAST);

    always_comb begin
        wd_d   = wd_q;
        terr_d = terr_q;
        if (in_start)
            wd_d = 8'd0;
        else if (in_wait)
            wd_d = wd_q + 8'd1;
        if (expire)
            terr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wd_q   <= 8'd0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    localparam int unused_to_cycles = TO_CYCLES;

    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        start_d = 1'b0;
        sel_d   = sel_q;
        x_d     = x_q;
        ypb_d   = ypb_q;
        ypm_d   = ypm_q;
        ypa_d   = ypa_q;
        dac_d   = dac_q;
        dv_d    = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    x_d    = x_in;
                    mask_d = band_en;
                    if (!band_en[0]) ypb_d = '0;
                    if (!band_en[1]) ypm_d = '0;
                    if (!band_en[2]) ypa_d = '0;
                    state_d = next_start(2'd0, band_en);
                end
            end
            START_L: state_d = WAIT_L;
            START_M: state_d = WAIT_M;
            START_H: state_d = WAIT_H;
            WAIT_L: begin
                if (advance) begin
                    ypb_d   = cap_val;
                    state_d = next_start(2'd1, mask_q);
                end
            end
            WAIT_M: begin
                if (advance) begin
                    ypm_d   = cap_val;
                    state_d = next_start(2'd2, mask_q);
                end
            end
            WAIT_H: begin
                if (advance) begin
                    ypa_d   = cap_val;
                    state_d = SUM;
                end
            end
            SUM: begin
                dac_d   = ys_in[11:0];
                dv_d    = 1'b1;
                state_d = OUT;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Start pulse and band select are registered for the START cycle itself.
        case (state_d)
            START_L: begin start_d = 1'b1; sel_d = 2'b00; end
            START_M: begin start_d = 1'b1; sel_d = 2'b01; end
            START_H: begin start_d = 1'b1; sel_d = 2'b10; end
            default: ;
        endcase

        if (ovr_clr)
            ovr_d = 1'b0;
        if (sample_valid && state_q != IDLE)
            ovr_d = 1'b1;
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            mask_q  <= 3'b000;
            start_q <= 1'b0;
            sel_q   <= 2'b00;
            x_q     <= 12'd0;
            ypb_q   <= '0;
            ypm_q   <= '0;
            ypa_q   <= '0;
            dac_q   <= 12'd0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            start_q <= start_d;
            sel_q   <= sel_d;
            x_q     <= x_d;
            ypb_q   <= ypb_d;
            ypm_q   <= ypm_d;
            ypa_q   <= ypa_d;
            dac_q   <= dac_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign filt_start = start_q;
    assign filt_sel   = sel_q;
    assign filt_x     = x_q;
    assign ypb        = ypb_q;
    assign ypm        = ypm_q;
    assign ypa        = ypa_q;
    assign dac_data   = dac_q;
    assign dac_valid  = dv_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_band_sequencer.sv
// Self-checking bench for band_sequencer: filter and summer models, vector table, overrun/reset/timeout sequences.
module tb_band_sequencer;

    localparam int W = 23;

    logic                clk = 1'b0;
    logic                Reset_n = 1'b0;
    logic                sample_valid = 1'b0;
    logic [11:0]         x_in = 12'd0;
    logic [2:0]          band_en = 3'b000;
    logic                ovr_clr = 1'b0;
    logic                filt_start;
    logic [1:0]          filt_sel;
    logic [11:0]         filt_x;
    logic                filt_done;
    logic signed [W-1:0] filt_y;
    logic signed [W-1:0] ypb, ypm, ypa;
    logic [15:0]         ys_in;
    logic [11:0]         dac_data;
    logic                dac_valid;
    logic                busy;
    logic                overrun;
    logic                timeout_err;

    int total = 0;
    int bad   = 0;

    logic signed [W-1:0] fres [3];
    int                  flat = 4;
    bit                  hang_mid = 1'b0;
    int                  fm_cnt = 0;
    logic [1:0]          fm_sel = 2'd0;
    int                  ss;

    band_sequencer #(.W(W), .TO_CYCLES(16)) dut (
        .clk(clk), .Reset_n(Reset_n), .sample_valid(sample_valid), .x_in(x_in),
        .band_en(band_en), .ovr_clr(ovr_clr), .filt_start(filt_start), .filt_sel(filt_sel),
        .filt_x(filt_x), .filt_done(filt_done), .filt_y(filt_y), .ypb(ypb), .ypm(ypm),
        .ypa(ypa), .ys_in(ys_in), .dac_data(dac_data), .dac_valid(dac_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Summer model: saturate to signed 12 bits, then add the 0x800 DAC offset.
    always_comb begin
        ss = int'(ypb) + int'(ypm) + int'(ypa);
        if (ss > 2047) ss = 2047;
        if (ss < -2048) ss = -2048;
        ys_in = 16'(ss + 2048);
    end

    // Filter model: done is high 'flat' cycles after the start cycle.
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fm_cnt = 0;
            filt_done <= 1'b0;
            filt_y    <= '0;
        end else begin
            filt_done <= 1'b0;
            if (filt_start && !(hang_mid && filt_sel == 2'd1)) begin
                fm_cnt = flat;
                fm_sel = filt_sel;
            end
            if (fm_cnt > 0) begin
                fm_cnt = fm_cnt - 1;
                if (fm_cnt == 0) begin
                    filt_done <= 1'b1;
                    filt_y    <= fres[fm_sel];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accept one sample in cycle 0, then observe cycles 1..win at the falling edge.
    task automatic run(input logic [2:0] en, input logic [11:0] x, input int inj, input bit inj_clr,
                       input int win, output int dvc, output int dvn, output logic [11:0] dac,
                       output int nst, output logic [5:0] sels);
        @(negedge clk);
        sample_valid = 1'b1;
        x_in = x;
        band_en = en;
        @(negedge clk);
        sample_valid = 1'b0;
        band_en = ~en;
        dvc = -1; dvn = 0; dac = 12'd0; nst = 0; sels = 6'd0;
        for (int c = 1; c <= win; c++) begin
            if (filt_start) begin
                if (nst < 3) sels[2*nst +: 2] = filt_sel;
                nst++;
            end
            if (dac_valid) begin
                dvn++;
                dvc = c;
                dac = dac_data;
            end
            sample_valid = (c == inj);
            ovr_clr = inj_clr && (c == inj);
            x_in = (c == inj) ? ~x : x;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        ovr_clr = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  en;
        int          lat;
        logic [22:0] rl, rm, rh;
        logic [11:0] x;
        int          e_cyc;
        int          e_nst;
        logic [5:0]  e_sels;
        logic [22:0] e_b, e_m, e_a;
        logic [11:0] e_dac;
    } vec_t;

    vec_t        vt [5];
    int          dvc, dvn, nst, cnt;
    logic [11:0] dac;
    logic [5:0]  sels;

    initial begin
        vt[0] = '{3'b111, 4, 23'h000100, 23'h000200, 23'h000300, 12'h123, 17, 3, 6'b100100,
                  23'h000100, 23'h000200, 23'h000300, 12'hE00};
        vt[1] = '{3'b010, 4, 23'h000100, 23'h000200, 23'h000300, 12'h456, 7, 1, 6'b000001,
                  23'h000000, 23'h000200, 23'h000000, 12'hA00};
        vt[2] = '{3'b000, 4, 23'h000100, 23'h000200, 23'h000300, 12'h789, 2, 0, 6'b000000,
                  23'h000000, 23'h000000, 23'h000000, 12'h800};
        vt[3] = '{3'b101, 1, 23'h7FFFF0, 23'h000777, 23'h000020, 12'hABC, 6, 2, 6'b001000,
                  23'h7FFFF0, 23'h000000, 23'h000020, 12'h810};
        vt[4] = '{3'b100, 2, 23'h000011, 23'h000022, 23'h000005, 12'hFED, 5, 1, 6'b000010,
                  23'h000000, 23'h000000, 23'h000005, 12'h805};

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, filt_start}, 32'd0);
        chk("rst_sel", {30'd0, filt_sel}, 32'd0);
        chk("rst_x", {20'd0, filt_x}, 32'd0);
        chk("rst_y", {$unsigned(ypb), $unsigned(ypm), $unsigned(ypa)} != 69'd0 ? 32'd1 : 32'd0, 32'd0);
        chk("rst_dac", {19'd0, dac_valid, dac_data}, 32'd0);
        chk("rst_flags", {30'd0, overrun, timeout_err}, 32'd0);
        @(negedge clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            flat = vt[i].lat;
            fres[0] = vt[i].rl; fres[1] = vt[i].rm; fres[2] = vt[i].rh;
            run(vt[i].en, vt[i].x, -1, 1'b0, 40, dvc, dvn, dac, nst, sels);
            chk($sformatf("v%0d_cycle", i), dvc, vt[i].e_cyc);
            chk($sformatf("v%0d_dvcount", i), dvn, 1);
            chk($sformatf("v%0d_dac", i), {20'd0, dac}, {20'd0, vt[i].e_dac});
            chk($sformatf("v%0d_starts", i), nst, vt[i].e_nst);
            chk($sformatf("v%0d_sels", i), {26'd0, sels}, {26'd0, vt[i].e_sels});
            chk($sformatf("v%0d_ypb", i), {9'd0, $unsigned(ypb)}, {9'd0, vt[i].e_b});
            chk($sformatf("v%0d_ypm", i), {9'd0, $unsigned(ypm)}, {9'd0, vt[i].e_m});
            chk($sformatf("v%0d_ypa", i), {9'd0, $unsigned(ypa)}, {9'd0, vt[i].e_a});
            chk($sformatf("v%0d_filtx", i), {20'd0, filt_x}, {20'd0, vt[i].x});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
        end
        chk("no_overrun", {31'd0, overrun}, 32'd0);

        // Overrun: drop in WAIT_M with ovr_clr in the same cycle (set wins), then in OUT.
        flat = 4;
        fres[0] = 23'h000100; fres[1] = 23'h000200; fres[2] = 23'h000300;
        run(3'b111, 12'h321, 8, 1'b1, 40, dvc, dvn, dac, nst, sels);
        chk("ovr1_flag", {31'd0, overrun}, 32'd1);
        chk("ovr1_starts", nst, 3);
        chk("ovr1_cycle", dvc, 17);
        chk("ovr1_dac", {20'd0, dac}, 32'h0E00);
        chk("ovr1_filtx", {20'd0, filt_x}, 32'h0321);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        run(3'b111, 12'h654, 17, 1'b0, 40, dvc, dvn, dac, nst, sels);
        chk("ovr2_flag", {31'd0, overrun}, 32'd1);
        chk("ovr2_starts", nst, 3);
        chk("ovr2_dvcount", dvn, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr2", {31'd0, overrun}, 32'd0);

        // Reset during WAIT_H (cycles 12..15) aborts the run.
        @(negedge clk);
        sample_valid = 1'b1; band_en = 3'b111; x_in = 12'h0F0;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_start", {31'd0, filt_start}, 32'd0);
        chk("arst_dv", {31'd0, dac_valid}, 32'd0);
        chk("arst_ypb", {9'd0, $unsigned(ypb)}, 32'd0);
        chk("arst_ypm", {9'd0, $unsigned(ypm)}, 32'd0);
        chk("arst_ypa", {9'd0, $unsigned(ypa)}, 32'd0);
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (dac_valid || busy) cnt++;
        end
        chk("arst_quiet", cnt, 0);
        run(3'b111, 12'h0F0, -1, 1'b0, 40, dvc, dvn, dac, nst, sels);
        chk("post_rst_cycle", dvc, 17);
        chk("post_rst_dac", {20'd0, dac}, 32'h0E00);
        chk("no_timeout", {31'd0, timeout_err}, 32'd0);

`ifdef BAND_SEQ_TIMEOUT_EN
        // Mid filter never answers: 16 WAIT cycles then the high band still runs.
        hang_mid = 1'b1;
        run(3'b111, 12'h0AA, -1, 1'b0, 45, dvc, dvn, dac, nst, sels);
        hang_mid = 1'b0;
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_ypm", {9'd0, $unsigned(ypm)}, 32'd0);
        chk("to_ypa", {9'd0, $unsigned(ypa)}, 32'h300);
        chk("to_cycle", dvc, 29);
        chk("to_starts", nst, 3);
        chk("to_dac", {20'd0, dac}, 32'h0C00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
